// File: rtl/rvv_retire_arb_pkg.sv
// Shared retire-stage definitions: write-back type encodings, the trap
// sequencing states and the per-lane ROB-to-retire record.
package rvv_retire_arb_pkg;

  localparam int RT_VREG_IDX_W = 5;
  localparam int RT_XREG_IDX_W = 5;
  localparam int RT_XLEN       = 32;

  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_VRF  = 2'b01;
  localparam logic [1:0] WB_XRF  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2,
    ST_FLUSH  = 2'd3
  } trap_state_e;

  typedef struct packed {
    logic                     valid;
    logic [1:0]               wb_type;
    logic [RT_VREG_IDX_W-1:0] vd;
    logic [RT_XREG_IDX_W-1:0] xd;
    logic [RT_XLEN-1:0]       xdata;
    logic                     trap;
  } ROB2RT_t;

endpackage

// File: rtl/rvv_retire_arb_xrf_slot.sv
// Single-entry scalar writeback holding register. A new load may land in
// the same cycle the current entry is accepted.
module rvv_retire_xrf_slot #(
  parameter int XREG_IDX_W = 5,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [XREG_IDX_W-1:0] load_rd,
  input  logic [XLEN-1:0]       load_data,
  input  logic                  ready,
  output logic                  valid,
  output logic [XREG_IDX_W-1:0] rd,
  output logic [XLEN-1:0]       data,
  output logic                  free
);

  // slot can take a new entry when empty or when the current one leaves now
  assign free = !valid || ready;

  // load wins over drain; otherwise hold while stalled, clear on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      rd    <= load_rd;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rvv_retire_arb.sv
// Retire arbiter: grants an in-order prefix of the ROB head window, drives
// VRF write enables, owns the scalar writeback slot and sequences traps.
//
// state     | meaning
// ST_IDLE   | normal retirement, prefix grants allowed
// ST_DRAIN  | oldest uop trapped, waiting for the XRF slot to empty
// ST_REPORT | trap_valid held until trap_ready
// ST_FLUSH  | one-cycle rob_flush pulse, then back to IDLE
module rvv_retire_arb
  import rvv_retire_arb_pkg::*;
#(
  parameter int NUM_RT_UOP = 4,
  parameter int VREG_IDX_W = RT_VREG_IDX_W,
  parameter int XREG_IDX_W = RT_XREG_IDX_W,
  parameter int XLEN       = RT_XLEN,
  parameter int CNT_W      = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_RT_UOP-1:0]                 rob2rt_write_valid,
  input  logic [NUM_RT_UOP-1:0][1:0]            rob2rt_wb_type,
  input  logic [NUM_RT_UOP-1:0][VREG_IDX_W-1:0] rob2rt_vd,
  input  logic [NUM_RT_UOP-1:0][XREG_IDX_W-1:0] rob2rt_xd,
  input  logic [NUM_RT_UOP-1:0][XLEN-1:0]       rob2rt_xdata,
  input  logic [NUM_RT_UOP-1:0]                 rob2rt_trap,
  output logic [NUM_RT_UOP-1:0]                 rt2rob_write_ready,
  output logic [NUM_RT_UOP-1:0]                 vrf_wen,
  output logic                                  rt2xrf_valid,
  output logic [XREG_IDX_W-1:0]                 rt2xrf_rd,
  output logic [XLEN-1:0]                       rt2xrf_data,
  input  logic                                  xrf2rt_ready,
  output logic                                  trap_valid,
  input  logic                                  trap_ready,
  output logic                                  rob_flush,
  output logic [CNT_W-1:0]                      retire_cnt
);

  ROB2RT_t [NUM_RT_UOP-1:0] lane;
  trap_state_e              state, state_d;
  logic                     slot_free;
  logic                     xrf_load;
  logic [XREG_IDX_W-1:0]    xrf_load_rd;
  logic [XLEN-1:0]          xrf_load_data;
  logic                     blocked, xrf_taken, lane_ok;
  logic [CNT_W-1:0]         retire_inc;

  // gather per-lane fields into one record per lane
  always_comb begin
    for (int i = 0; i < NUM_RT_UOP; i++) begin
      lane[i].valid   = rob2rt_write_valid[i];
      lane[i].wb_type = rob2rt_wb_type[i];
      lane[i].vd      = rob2rt_vd[i];
      lane[i].xd      = rob2rt_xd[i];
      lane[i].xdata   = rob2rt_xdata[i];
      lane[i].trap    = rob2rt_trap[i];
    end
  end

  // in-order prefix grant; first failing lane blocks all younger lanes.
  // Every lane below i is granted whenever lane i is still reachable, so the
  // WAW check only needs to look at earlier lane types.
  always_comb begin
    rt2rob_write_ready = '0;
    blocked            = 1'b0;
    xrf_taken          = 1'b0;
    lane_ok            = 1'b0;
    xrf_load           = 1'b0;
    xrf_load_rd        = '0;
    xrf_load_data      = '0;
    for (int i = 0; i < NUM_RT_UOP; i++) begin
      lane_ok = lane[i].valid && !lane[i].trap && (state == ST_IDLE);
      if (lane[i].wb_type == WB_VRF) begin
        for (int j = 0; j < NUM_RT_UOP; j++) begin
          if (j < i && lane[j].wb_type == WB_VRF && lane[j].vd == lane[i].vd) lane_ok = 1'b0;
        end
      end else if (lane[i].wb_type == WB_XRF) begin
        if (xrf_taken || !slot_free) lane_ok = 1'b0;
        xrf_taken = 1'b1;
      end
      if (blocked || !lane_ok) begin
        blocked = 1'b1;
      end else begin
        rt2rob_write_ready[i] = 1'b1;
        if (lane[i].wb_type == WB_XRF) begin
          xrf_load      = 1'b1;
          xrf_load_rd   = lane[i].xd;
          xrf_load_data = lane[i].xdata;
        end
      end
    end
  end

  // VRF enables and the per-cycle retire count
  always_comb begin
    vrf_wen    = '0;
    retire_inc = '0;
    for (int i = 0; i < NUM_RT_UOP; i++) begin
      vrf_wen[i] = rt2rob_write_ready[i] && (lane[i].wb_type == WB_VRF);
      retire_inc = retire_inc + CNT_W'(rt2rob_write_ready[i] & lane[i].valid);
    end
  end

  rvv_retire_xrf_slot #(
    .XREG_IDX_W (XREG_IDX_W),
    .XLEN       (XLEN)
  ) u_xrf_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (xrf_load),
    .load_rd   (xrf_load_rd),
    .load_data (xrf_load_data),
    .ready     (xrf2rt_ready),
    .valid     (rt2xrf_valid),
    .rd        (rt2xrf_rd),
    .data      (rt2xrf_data),
    .free      (slot_free)
  );

  // trap FSM state register and retired-uop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      retire_cnt <= '0;
    end else begin
      state      <= state_d;
      retire_cnt <= retire_cnt + retire_inc;
    end
  end

  // trap FSM next state and state-decoded outputs
  always_comb begin
    state_d    = state;
    trap_valid = 1'b0;
    rob_flush  = 1'b0;
    case (state)
      ST_IDLE:   if (rob2rt_write_valid[0] && rob2rt_trap[0]) state_d = ST_DRAIN;
      ST_DRAIN:  if (!rt2xrf_valid) state_d = ST_REPORT;
      ST_REPORT: begin
        trap_valid = 1'b1;
        if (trap_ready) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        rob_flush = 1'b1;
        state_d   = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rvv_retire_arb.sv
// Bench for rvv_retire_arb: single-cycle grant table, directed multi-cycle
// sequences and random traffic against a queue-based ROB model.
module tb_rvv_retire_arb;
  import rvv_retire_arb_pkg::*;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         valid_i = '0;
  logic [N-1:0][1:0]    wb_i = '0;
  logic [N-1:0][4:0]    vd_i = '0;
  logic [N-1:0][4:0]    xd_i = '0;
  logic [N-1:0][31:0]   xdata_i = '0;
  logic [N-1:0]         trap_i = '0;
  logic [N-1:0]         ready_o, wen_o;
  logic                 xv_o;
  logic [4:0]           xrd_o;
  logic [31:0]          xdat_o;
  logic                 xready_i = 1'b1;
  logic                 tv_o, flush_o;
  logic                 tready_i = 1'b0;
  logic [31:0]          cnt_o;

  always #5 clk = ~clk;

  rvv_retire_arb dut (
    .clk                (clk),
    .rst                (rst),
    .rob2rt_write_valid (valid_i),
    .rob2rt_wb_type     (wb_i),
    .rob2rt_vd          (vd_i),
    .rob2rt_xd          (xd_i),
    .rob2rt_xdata       (xdata_i),
    .rob2rt_trap        (trap_i),
    .rt2rob_write_ready (ready_o),
    .vrf_wen            (wen_o),
    .rt2xrf_valid       (xv_o),
    .rt2xrf_rd          (xrd_o),
    .rt2xrf_data        (xdat_o),
    .xrf2rt_ready       (xready_i),
    .trap_valid         (tv_o),
    .trap_ready         (tready_i),
    .rob_flush          (flush_o),
    .retire_cnt         (cnt_o)
  );

  typedef struct {
    logic [1:0]  wb;
    logic [4:0]  vd;
    logic [4:0]  xd;
    logic [31:0] xdata;
    logic        trap;
  } uop_t;

  typedef struct {
    logic [3:0]  valid;
    logic [7:0]  wb;
    logic [19:0] vd;
    logic [3:0]  trap;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_wen;
  } vec_t;

  uop_t        q[$];
  int          m_phase;
  logic        m_sv;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] m_cnt;
  int          total = 0;
  int          bad = 0;
  vec_t        tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] wb, input int vd, input int xd, input logic [31:0] xd_data, input logic tr);
    uop_t u;
    u.wb = wb; u.vd = 5'(vd); u.xd = 5'(xd); u.xdata = xd_data; u.trap = tr;
    q.push_back(u);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_i = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    m_phase = 0; m_sv = 1'b0; m_rd = '0; m_data = '0; m_cnt = '0;
    chk("rst_xrf_valid", 32'(xv_o), 32'd0);
    chk("rst_trap_valid", 32'(tv_o), 32'd0);
    chk("rst_rob_flush", 32'(flush_o), 32'd0);
    chk("rst_retire_cnt", cnt_o, 32'd0);
  endtask

  // One cycle: present the model ROB head, check DUT against the model at
  // the falling edge, then advance the model across the rising edge.
  task automatic run_cycle();
    logic [3:0] g, w;
    int         n, nph;
    bit         ok, xused, load;
    uop_t       lu;
    for (int i = 0; i < N; i++) begin
      if (i < q.size()) begin
        valid_i[i] = 1'b1; wb_i[i] = q[i].wb; vd_i[i] = q[i].vd;
        xd_i[i] = q[i].xd; xdata_i[i] = q[i].xdata; trap_i[i] = q[i].trap;
      end else begin
        valid_i[i] = 1'b0; wb_i[i] = 2'($urandom); vd_i[i] = 5'($urandom);
        xd_i[i] = 5'($urandom); xdata_i[i] = $urandom; trap_i[i] = 1'($urandom);
      end
    end
    @(negedge clk);
    g = '0; w = '0; n = 0; xused = 0;
    if (m_phase == 0) begin
      for (int i = 0; i < N && i < q.size(); i++) begin
        ok = !q[i].trap;
        if (q[i].wb == WB_VRF)
          for (int j = 0; j < i; j++)
            if (q[j].wb == WB_VRF && q[j].vd == q[i].vd) ok = 0;
        if (q[i].wb == WB_XRF) begin
          if (xused || (m_sv && !xready_i)) ok = 0;
          xused = 1;
        end
        if (!ok) break;
        g[i] = 1'b1;
        w[i] = (q[i].wb == WB_VRF);
        n++;
      end
    end
    chk("grant", 32'(ready_o), 32'(g));
    chk("vrf_wen", 32'(wen_o), 32'(w));
    chk("xrf_valid", 32'(xv_o), 32'(m_sv));
    if (m_sv) begin
      chk("xrf_rd", 32'(xrd_o), 32'(m_rd));
      chk("xrf_data", xdat_o, m_data);
    end
    chk("trap_valid", 32'(tv_o), 32'(m_phase == 2));
    chk("rob_flush", 32'(flush_o), 32'(m_phase == 3));
    chk("retire_cnt", cnt_o, m_cnt);

    nph = m_phase;
    case (m_phase)
      0: if (q.size() > 0 && q[0].trap) nph = 1;
      1: if (!m_sv) nph = 2;
      2: if (tready_i) nph = 3;
      default: nph = 0;
    endcase
    load = 0;
    for (int k = 0; k < n; k++)
      if (q[k].wb == WB_XRF) begin load = 1; lu = q[k]; end
    for (int k = 0; k < n; k++) begin
      q.delete(0);
      m_cnt = m_cnt + 32'd1;
    end
    if (load) begin
      m_sv = 1'b1; m_rd = lu.xd; m_data = lu.xdata;
    end else if (m_sv && xready_i) begin
      m_sv = 1'b0;
    end
    if (m_phase == 3) q.delete();
    m_phase = nph;
    @(posedge clk); #1;
  endtask

  task automatic run_n(input int cycles);
    for (int c = 0; c < cycles; c++) run_cycle();
  endtask

  initial begin
    // valid, wb {l3,l2,l1,l0}, vd {l3,l2,l1,l0}, trap, exp_ready, exp_wen
    tbl[0]  = '{4'b1111, 8'b01_01_01_01, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 4'b1111, 4'b1111};
    tbl[1]  = '{4'b1111, 8'b01_01_01_01, {5'd7, 5'd5, 5'd6, 5'd5}, 4'b0000, 4'b0011, 4'b0011};
    tbl[2]  = '{4'b1111, 8'b01_10_10_01, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 4'b0011, 4'b0001};
    tbl[3]  = '{4'b1111, 8'b01_01_01_01, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0100, 4'b0011, 4'b0011};
    tbl[4]  = '{4'b1011, 8'b01_01_01_01, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 4'b0011, 4'b0011};
    tbl[5]  = '{4'b1111, 8'b01_01_01_01, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0001, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b1111, 8'b01_01_11_00, {5'd9, 5'd8, 5'd3, 5'd3}, 4'b0000, 4'b1111, 4'b1100};
    tbl[7]  = '{4'b1111, 8'b01_01_00_01, {5'd10, 5'd9, 5'd9, 5'd9}, 4'b0000, 4'b0011, 4'b0001};
    tbl[8]  = '{4'b0000, 8'b01_01_01_01, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0001, 8'b00_00_00_10, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 4'b0001, 4'b0000};
    tbl[10] = '{4'b1111, 8'b10_01_01_10, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 4'b0111, 4'b0110};

    // single-cycle grant table, each from a fresh reset
    for (int k = 0; k < 11; k++) begin
      do_reset();
      valid_i = tbl[k].valid; wb_i = tbl[k].wb; vd_i = tbl[k].vd;
      trap_i = tbl[k].trap; xd_i = '0; xdata_i = '0; xready_i = 1'b1;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", k), 32'(ready_o), 32'(tbl[k].exp_ready));
      chk($sformatf("tbl%0d_wen", k), 32'(wen_o), 32'(tbl[k].exp_wen));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_cnt", k), cnt_o, 32'($countones(tbl[k].exp_ready)));
    end

    // same-cycle WAW: later vd 5 retires on the following cycle
    do_reset();
    xready_i = 1'b1; tready_i = 1'b0;
    push(WB_VRF, 5, 0, 0, 0); push(WB_VRF, 6, 0, 0, 0);
    push(WB_VRF, 5, 0, 0, 0); push(WB_VRF, 7, 0, 0, 0);
    run_n(3);

    // two XRF lanes: only the first goes, writeback appears next cycle
    push(WB_VRF, 1, 0, 0, 0); push(WB_XRF, 0, 3, 32'hA5, 0);
    push(WB_XRF, 0, 4, 32'h5A, 0); push(WB_VRF, 2, 0, 0, 0);
    run_n(5);

    // slot stalled three cycles, then drain and reload together
    do_reset();
    push(WB_XRF, 0, 1, 32'h11, 0); push(WB_XRF, 0, 2, 32'h22, 0);
    push(WB_XRF, 0, 3, 32'h33, 0);
    xready_i = 1'b0;
    run_n(4);
    xready_i = 1'b1;
    run_n(4);

    // trap reaches lane 0 with the slot still pending
    do_reset();
    push(WB_VRF, 1, 0, 0, 0); push(WB_XRF, 0, 7, 32'hDEAD_BEEF, 0);
    push(WB_VRF, 2, 0, 0, 1); push(WB_VRF, 3, 0, 0, 0);
    xready_i = 1'b0; tready_i = 1'b0;
    run_n(5);
    xready_i = 1'b1;
    run_n(3);
    tready_i = 1'b1;
    run_n(3);
    chk("trap_seq_cnt", cnt_o, 32'd2);

    // reset while the trap report is outstanding
    do_reset();
    push(WB_VRF, 4, 0, 0, 1);
    xready_i = 1'b1; tready_i = 1'b0;
    run_n(3);
    chk("in_report", 32'(tv_o), 32'd1);
    do_reset();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      while (q.size() < 6)
        push(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 31),
             $urandom, ($urandom_range(0, 15) == 0));
      xready_i = ($urandom_range(0, 3) != 0);
      tready_i = 1'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      else run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
